// File: rtl/rd_txn_store.sv
`default_nettype none
// ============================================================================
// Module   : rd_txn_store (with rd_txn_store_pkg)
// Purpose  : State stage behind the read transaction manager. Registers the
//            manager's next head/tail table and linked-data array, ages the
//            timeout counter of every outstanding read, and derives the
//            lookups the manager consumes next cycle (free slots, full,
//            AR/R ID matches, accumulated outstanding burst length).
// Ports    : clk_i, rst_i (async, active-high), presc_i (prescaler reload),
//            enq_i, head_tail_d_i, linked_data_d_i, match_in_id_i,
//            match_in_id_valid_i, rsp_id_i -> head_tail_q_o,
//            linked_data_q_o, head_tail_free_idx_o, linked_data_free_idx_o,
//            full_o, no_in_id_match_o, match_in_idx_o, id_exists_o,
//            rsp_idx_o, accum_burst_length_o.
// Options  : RD_STORE_PRESCALER_EN - age counters only on prescaler ticks;
//            when undefined, aging happens every cycle and presc_i is unused.
// Revision : 1.0 - initial release
// ============================================================================

package rd_txn_store_pkg;
    localparam int PKG_MAX_RD_TXNS = 8;
    localparam int PKG_HT_CAPACITY = 8;
    localparam int PKG_ID_WIDTH    = 4;
    localparam int PKG_ACCU_WIDTH  = 16;

    typedef logic [PKG_ID_WIDTH-1:0]              id_t;
    typedef logic [PKG_ACCU_WIDTH-1:0]            accu_cnt_t;
    typedef logic [$clog2(PKG_HT_CAPACITY)-1:0]   ht_idx_t;
    typedef logic [$clog2(PKG_MAX_RD_TXNS)-1:0]   ld_idx_t;

    typedef struct packed {
        id_t        id;
        logic [7:0] len;
    } metadata_t;

    typedef struct packed {
        metadata_t  metadata;
        accu_cnt_t  counter;
        ld_idx_t    next;
        logic       free;
    } linked_data_t;

    typedef struct packed {
        id_t        id;
        ld_idx_t    head;
        ld_idx_t    tail;
        logic       free;
    } head_tail_t;
endpackage

module rd_txn_store
    import rd_txn_store_pkg::*;
#(
    parameter int MAX_RD_TXNS = PKG_MAX_RD_TXNS,
    parameter int HT_CAPACITY = PKG_HT_CAPACITY
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [3:0]                    presc_i,
    input  logic                          enq_i,
    input  head_tail_t   [HT_CAPACITY-1:0] head_tail_d_i,
    input  linked_data_t [MAX_RD_TXNS-1:0] linked_data_d_i,
    input  id_t                           match_in_id_i,
    input  logic                          match_in_id_valid_i,
    input  id_t                           rsp_id_i,
    output head_tail_t   [HT_CAPACITY-1:0] head_tail_q_o,
    output linked_data_t [MAX_RD_TXNS-1:0] linked_data_q_o,
    output ht_idx_t                       head_tail_free_idx_o,
    output ld_idx_t                       linked_data_free_idx_o,
    output logic                          full_o,
    output logic                          no_in_id_match_o,
    output ht_idx_t                       match_in_idx_o,
    output logic                          id_exists_o,
    output ht_idx_t                       rsp_idx_o,
    output accu_cnt_t                     accum_burst_length_o
);

    // Wide enough that MAX_RD_TXNS * 256 can never overflow.
    localparam int c_sum_w = 9 + $clog2(MAX_RD_TXNS + 1);

    localparam linked_data_t c_ld_reset = '{metadata: '0, counter: '0, next: '0, free: 1'b1};
    localparam head_tail_t   c_ht_reset = '{id: '0, head: '0, tail: '0, free: 1'b1};

    head_tail_t   [HT_CAPACITY-1:0] r_head_tail_q;
    linked_data_t [MAX_RD_TXNS-1:0] r_linked_data_q;
    linked_data_t [MAX_RD_TXNS-1:0] w_linked_data_aged;

    logic               w_tick;
    ld_idx_t            w_ld_free_idx;
    logic               w_ld_any_free;
    ht_idx_t            w_ht_free_idx;
    logic               w_ht_any_free;
    ht_idx_t            w_in_idx;
    logic               w_in_found;
    ht_idx_t            w_rsp_idx;
    logic               w_rsp_found;
    logic [c_sum_w-1:0] w_burst_sum;
    accu_cnt_t          w_accum;

    // ------------------------------------------------------------------
    // Aging tick source
    // ------------------------------------------------------------------
`ifdef RD_STORE_PRESCALER_EN
    logic [3:0] r_presc_cnt;

    assign w_tick = (r_presc_cnt == 4'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_presc_cnt <= 4'd0;
        end else if (w_tick) begin
            r_presc_cnt <= presc_i;
        end else begin
            r_presc_cnt <= r_presc_cnt - 4'd1;
        end
    end
`else
    logic w_unused_presc;
    assign w_unused_presc = ^presc_i;
    assign w_tick         = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Aging: saturating decrement of live counters. The slot being filled
    // this cycle keeps its freshly loaded budget untouched.
    // ------------------------------------------------------------------
    always_comb begin
        w_linked_data_aged = linked_data_d_i;
        for (int i = 0; i < MAX_RD_TXNS; i++) begin
            if (w_tick && !linked_data_d_i[i].free &&
                (linked_data_d_i[i].counter != '0) &&
                !(enq_i && (ld_idx_t'(i) == w_ld_free_idx))) begin
                w_linked_data_aged[i].counter = linked_data_d_i[i].counter - accu_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < HT_CAPACITY; i++) begin
                r_head_tail_q[i] <= c_ht_reset;
            end
            for (int i = 0; i < MAX_RD_TXNS; i++) begin
                r_linked_data_q[i] <= c_ld_reset;
            end
        end else begin
            r_head_tail_q   <= head_tail_d_i;
            r_linked_data_q <= w_linked_data_aged;
        end
    end

    // ------------------------------------------------------------------
    // Lookups (all from registered state). Loops run high-to-low so the
    // last hit written is the lowest index.
    // ------------------------------------------------------------------
    always_comb begin
        w_ld_free_idx = '0;
        w_ld_any_free = 1'b0;
        for (int i = MAX_RD_TXNS - 1; i >= 0; i--) begin
            if (r_linked_data_q[i].free) begin
                w_ld_free_idx = ld_idx_t'(i);
                w_ld_any_free = 1'b1;
            end
        end
    end

    always_comb begin
        w_ht_free_idx = '0;
        w_ht_any_free = 1'b0;
        w_in_idx      = '0;
        w_in_found    = 1'b0;
        w_rsp_idx     = '0;
        w_rsp_found   = 1'b0;
        for (int i = HT_CAPACITY - 1; i >= 0; i--) begin
            if (r_head_tail_q[i].free) begin
                w_ht_free_idx = ht_idx_t'(i);
                w_ht_any_free = 1'b1;
            end else begin
                if (r_head_tail_q[i].id == match_in_id_i) begin
                    w_in_idx   = ht_idx_t'(i);
                    w_in_found = 1'b1;
                end
                if (r_head_tail_q[i].id == rsp_id_i) begin
                    w_rsp_idx   = ht_idx_t'(i);
                    w_rsp_found = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_burst_sum = '0;
        for (int i = 0; i < MAX_RD_TXNS; i++) begin
            if (!r_linked_data_q[i].free) begin
                w_burst_sum = w_burst_sum + c_sum_w'(r_linked_data_q[i].metadata.len) + c_sum_w'(1);
            end
        end
    end

    generate
        if (c_sum_w > PKG_ACCU_WIDTH) begin : g_sat
            assign w_accum = (|w_burst_sum[c_sum_w-1:PKG_ACCU_WIDTH]) ? '1
                                                                      : w_burst_sum[PKG_ACCU_WIDTH-1:0];
        end else begin : g_nosat
            assign w_accum = accu_cnt_t'(w_burst_sum);
        end
    endgenerate

    assign head_tail_q_o          = r_head_tail_q;
    assign linked_data_q_o        = r_linked_data_q;
    assign head_tail_free_idx_o   = w_ht_free_idx;
    assign linked_data_free_idx_o = w_ld_free_idx;
    assign full_o                 = !w_ld_any_free || !w_ht_any_free;
    assign no_in_id_match_o       = !(match_in_id_valid_i && w_in_found);
    assign match_in_idx_o         = match_in_id_valid_i ? w_in_idx : '0;
    assign id_exists_o            = w_rsp_found;
    assign rsp_idx_o              = w_rsp_idx;
    assign accum_burst_length_o   = w_accum;

endmodule

`default_nettype wire

// File: tb/tb_rd_txn_store.sv
`default_nettype none
// ============================================================================
// Module   : tb_rd_txn_store
// Purpose  : Self-checking bench for rd_txn_store. A vector table drives
//            allocate/free operations and lookup IDs, expected results are
//            queued at drive time and compared one cycle later; hand-written
//            sequences cover counter aging, saturation, and async reset.
//            Compile with RD_STORE_PRESCALER_EN to exercise the prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rd_txn_store;
    import rd_txn_store_pkg::*;

    localparam int NL = PKG_MAX_RD_TXNS;
    localparam int NH = PKG_HT_CAPACITY;
    localparam int NV = 16;

    logic                    clk_i = 1'b0;
    logic                    rst_i;
    logic [3:0]              presc_i;
    logic                    enq_i;
    head_tail_t   [NH-1:0]   head_tail_d_i;
    linked_data_t [NL-1:0]   linked_data_d_i;
    id_t                     match_in_id_i;
    logic                    match_in_id_valid_i;
    id_t                     rsp_id_i;
    head_tail_t   [NH-1:0]   head_tail_q_o;
    linked_data_t [NL-1:0]   linked_data_q_o;
    ht_idx_t                 head_tail_free_idx_o;
    ld_idx_t                 linked_data_free_idx_o;
    logic                    full_o;
    logic                    no_in_id_match_o;
    ht_idx_t                 match_in_idx_o;
    logic                    id_exists_o;
    ht_idx_t                 rsp_idx_o;
    accu_cnt_t               accum_burst_length_o;

    rd_txn_store dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .presc_i                (presc_i),
        .enq_i                  (enq_i),
        .head_tail_d_i          (head_tail_d_i),
        .linked_data_d_i        (linked_data_d_i),
        .match_in_id_i          (match_in_id_i),
        .match_in_id_valid_i    (match_in_id_valid_i),
        .rsp_id_i               (rsp_id_i),
        .head_tail_q_o          (head_tail_q_o),
        .linked_data_q_o        (linked_data_q_o),
        .head_tail_free_idx_o   (head_tail_free_idx_o),
        .linked_data_free_idx_o (linked_data_free_idx_o),
        .full_o                 (full_o),
        .no_in_id_match_o       (no_in_id_match_o),
        .match_in_idx_o         (match_in_idx_o),
        .id_exists_o            (id_exists_o),
        .rsp_idx_o              (rsp_idx_o),
        .accum_burst_length_o   (accum_burst_length_o)
    );

    always #5 clk_i = ~clk_i;

    // op codes: 0 = none, 1 = allocate, 2 = free
    typedef struct {
        int ld_op; int ld_idx; int len;
        int ht_op; int ht_idx; int id;
        int match_id; int match_v; int rsp_id;
        int e_ld_free; int e_ht_free; int e_full; int e_accum;
        int e_no_match; int e_match_idx; int e_exists; int e_rsp_idx;
    } vec_t;

    typedef struct {
        int tag;
        int ld_free; int ht_free; int full; int accum;
        int no_match; int match_idx; int exists; int rsp_idx;
        int ld_mask; int ht_mask;
    } exp_t;

    vec_t     vecs [NV];
    exp_t     sb [$];
    int       checks   = 0;
    int       failures = 0;
    logic [NL-1:0] m_ld_free;
    logic [NH-1:0] m_ht_free;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int ld_mask(input linked_data_t [NL-1:0] a);
        int m = 0;
        for (int i = 0; i < NL; i++) if (a[i].free) m |= (1 << i);
        return m;
    endfunction

    function automatic int ht_mask(input head_tail_t [NH-1:0] a);
        int m = 0;
        for (int i = 0; i < NH; i++) if (a[i].free) m |= (1 << i);
        return m;
    endfunction

    task automatic clear_inputs();
        enq_i = 1'b0;
        for (int i = 0; i < NL; i++)
            linked_data_d_i[i] = '{metadata: '0, counter: '0, next: '0, free: 1'b1};
        for (int i = 0; i < NH; i++)
            head_tail_d_i[i] = '{id: '0, head: '0, tail: '0, free: 1'b1};
        m_ld_free = '1;
        m_ht_free = '1;
    endtask

    task automatic check_all_free(input string tag);
        chk({tag, " ld_free_mask"}, ld_mask(linked_data_q_o), (1 << NL) - 1);
        chk({tag, " ht_free_mask"}, ht_mask(head_tail_q_o), (1 << NH) - 1);
        chk({tag, " accum"}, int'(accum_burst_length_o), 0);
        chk({tag, " full"}, int'(full_o), 0);
        chk({tag, " ld_free_idx"}, int'(linked_data_free_idx_o), 0);
    endtask

    initial begin
        int    exp0;
        int    exp1;
        exp_t  e;
        vec_t  v;

        //         ld_op idx len  ht_op idx id  mid mv rsp  ldf htf full accum nom midx ex ridx
        vecs[0]  = '{1, 0,   3,   1, 0, 5,   5, 1, 3,   1, 1, 0,  4,   0, 0, 0, 0};
        vecs[1]  = '{1, 1,  15,   1, 1, 7,   7, 0, 5,   2, 2, 0, 20,   1, 0, 1, 0};
        vecs[2]  = '{2, 0,   0,   1, 2, 3,   3, 1, 3,   0, 3, 0, 16,   0, 2, 1, 2};
        vecs[3]  = '{1, 0,   0,   1, 3, 3,   3, 1, 9,   2, 4, 0, 17,   0, 2, 0, 0};
        vecs[4]  = '{1, 2, 255,   2, 2, 0,   3, 1, 3,   3, 2, 0, 273,  0, 3, 1, 3};
        vecs[5]  = '{1, 3,   1,   0, 0, 0,   9, 1, 7,   4, 2, 0, 275,  1, 0, 1, 1};
        vecs[6]  = '{1, 4,   1,   1, 2, 9,   9, 1, 9,   5, 4, 0, 277,  0, 2, 1, 2};
        vecs[7]  = '{1, 5,   0,   0, 0, 0,   5, 1, 0,   6, 4, 0, 278,  0, 0, 0, 0};
        vecs[8]  = '{1, 6,   0,   0, 0, 0,   7, 1, 3,   7, 4, 0, 279,  0, 1, 1, 3};
        vecs[9]  = '{1, 7,   0,   0, 0, 0,   7, 1, 7,   0, 4, 1, 280,  0, 1, 1, 1};
        vecs[10] = '{2, 5,   0,   0, 0, 0,   3, 1, 3,   5, 4, 0, 279,  0, 3, 1, 3};
        vecs[11] = '{1, 5,   0,   1, 4, 4,   4, 1, 4,   0, 5, 1, 280,  0, 4, 1, 4};
        vecs[12] = '{0, 0,   0,   1, 5, 4,   4, 1, 2,   0, 6, 1, 280,  0, 4, 0, 0};
        vecs[13] = '{2, 7,   0,   1, 6, 6,   6, 1, 6,   7, 7, 0, 279,  0, 6, 1, 6};
        vecs[14] = '{0, 0,   0,   1, 7, 1,   1, 1, 1,   7, 0, 1, 279,  0, 7, 1, 7};
        vecs[15] = '{0, 0,   0,   2, 0, 0,   5, 1, 5,   7, 0, 0, 279,  1, 0, 0, 0};

        // ---------------- reset state ----------------
        rst_i = 1'b1;
        presc_i = 4'd0;
        match_in_id_i = '0;
        match_in_id_valid_i = 1'b1;
        rsp_id_i = '0;
        clear_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        check_all_free("reset");
        chk("reset ht_free_idx", int'(head_tail_free_idx_o), 0);
        chk("reset no_match", int'(no_in_id_match_o), 1);
        chk("reset match_idx", int'(match_in_idx_o), 0);
        chk("reset id_exists", int'(id_exists_o), 0);
        chk("reset rsp_idx", int'(rsp_idx_o), 0);

        // ---------------- table-driven vectors ----------------
        for (int t = 0; t < NV; t++) begin
            v = vecs[t];
            if (v.ld_op != 0) begin
                linked_data_d_i[v.ld_idx].metadata.len = 8'(v.len);
                linked_data_d_i[v.ld_idx].metadata.id  = id_t'(v.id);
                linked_data_d_i[v.ld_idx].counter      = '0;
                linked_data_d_i[v.ld_idx].free         = (v.ld_op == 2);
                m_ld_free[v.ld_idx]                    = (v.ld_op == 2);
            end
            if (v.ht_op != 0) begin
                if (v.ht_op == 1) head_tail_d_i[v.ht_idx].id = id_t'(v.id);
                head_tail_d_i[v.ht_idx].free = (v.ht_op == 2);
                m_ht_free[v.ht_idx]          = (v.ht_op == 2);
            end
            match_in_id_i       = id_t'(v.match_id);
            match_in_id_valid_i = (v.match_v != 0);
            rsp_id_i            = id_t'(v.rsp_id);
            sb.push_back('{t, v.e_ld_free, v.e_ht_free, v.e_full, v.e_accum,
                           v.e_no_match, v.e_match_idx, v.e_exists, v.e_rsp_idx,
                           int'(m_ld_free), int'(m_ht_free)});
            @(posedge clk_i);
            #1;
            e = sb.pop_front();
            chk($sformatf("v%0d ld_free_idx", e.tag), int'(linked_data_free_idx_o), e.ld_free);
            chk($sformatf("v%0d ht_free_idx", e.tag), int'(head_tail_free_idx_o), e.ht_free);
            chk($sformatf("v%0d full", e.tag), int'(full_o), e.full);
            chk($sformatf("v%0d accum", e.tag), int'(accum_burst_length_o), e.accum);
            chk($sformatf("v%0d no_match", e.tag), int'(no_in_id_match_o), e.no_match);
            chk($sformatf("v%0d match_idx", e.tag), int'(match_in_idx_o), e.match_idx);
            chk($sformatf("v%0d id_exists", e.tag), int'(id_exists_o), e.exists);
            chk($sformatf("v%0d rsp_idx", e.tag), int'(rsp_idx_o), e.rsp_idx);
            chk($sformatf("v%0d ld_mask", e.tag), ld_mask(linked_data_q_o), e.ld_mask);
            chk($sformatf("v%0d ht_mask", e.tag), ht_mask(head_tail_q_o), e.ht_mask);
        end

        // ---------------- async reset mid-operation ----------------
        rst_i = 1'b1;
        #1;
        check_all_free("midreset1");
        clear_inputs();
        #1;
        rst_i = 1'b0;

`ifdef RD_STORE_PRESCALER_EN
        // ---------------- prescaler aging ----------------
        presc_i = 4'd3;
        linked_data_d_i[0] = '{metadata: '{id: 4'd3, len: 8'd7}, counter: 16'd10, next: '0, free: 1'b0};
        head_tail_d_i[0]   = '{id: 4'd3, head: '0, tail: '0, free: 1'b0};
        enq_i = 1'b1;
        exp0 = 10;
        for (int n = 1; n <= 13; n++) begin
            @(posedge clk_i);
            #1;
            chk($sformatf("presc cnt n%0d", n), int'(linked_data_q_o[0].counter), 10 - (n - 1) / 4);
            enq_i = 1'b0;
            exp0 = 10 - (n - 1) / 4;
            linked_data_d_i[0].counter = 16'(exp0);
        end
`else
        // ---------------- per-cycle aging and saturation ----------------
        linked_data_d_i[0] = '{metadata: '{id: 4'd3, len: 8'd7}, counter: 16'd20, next: '0, free: 1'b0};
        linked_data_d_i[1] = '{metadata: '{id: 4'd3, len: 8'd0}, counter: 16'd5, next: '0, free: 1'b0};
        head_tail_d_i[0]   = '{id: 4'd3, head: '0, tail: 3'd1, free: 1'b0};
        enq_i = 1'b1;
        @(posedge clk_i);
        #1;
        exp0 = 20;
        exp1 = 4;
        chk("age load exempt", int'(linked_data_q_o[0].counter), exp0);
        chk("age load other", int'(linked_data_q_o[1].counter), exp1);
        enq_i = 1'b0;
        for (int k = 1; k <= 22; k++) begin
            linked_data_d_i[0].counter = 16'(exp0);
            linked_data_d_i[1].counter = 16'(exp1);
            exp0 = (exp0 > 0) ? exp0 - 1 : 0;
            exp1 = (exp1 > 0) ? exp1 - 1 : 0;
            @(posedge clk_i);
            #1;
            chk($sformatf("age cnt0 k%0d", k), int'(linked_data_q_o[0].counter), exp0);
            chk($sformatf("age cnt1 k%0d", k), int'(linked_data_q_o[1].counter), exp1);
        end
`endif

        // ---------------- async reset mid-count ----------------
        rst_i = 1'b1;
        #1;
        check_all_free("midreset2");
        chk("midreset2 cnt0", int'(linked_data_q_o[0].counter), 0);
        clear_inputs();
        #1;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/rd_txn_store.md
# rd_txn_store

State-holding stage that sits directly downstream of the read transaction manager. It registers the manager's next-state head/tail table and linked-data array, and ages every outstanding read's timeout counter. It also derives the lookup results the manager consumes in the next cycle: free slots, full, ID matches, response index and accumulated outstanding burst length. All lookups are combinational from registered state; all state updates are synchronous.

## Interface
Parameters:
- MaxRdTxns, 8, linked-data entries (outstanding reads)
- HtCapacity, 8, head/tail entries (distinct outstanding IDs)
- linked_data_t, logic, struct {metadata{id, len[7:0]}, counter, next, free}
- head_tail_t, logic, struct {id, head, tail, free}
- ht_idx_t, logic, index into head/tail table ($clog2(HtCapacity))
- ld_idx_t, logic, index into linked data ($clog2(MaxRdTxns))
- id_t, logic, AXI ID
- accu_cnt_t, logic, counter/accumulator type (16 bits typical)

Ports:
- clk_i, in, 1, clock
- rst_i, in, 1, reset, asynchronous, active-high
- presc_i, in, 4, prescaler reload from register file
- enq_i, in, 1, manager enqueued into linked_data_free_idx_o this cycle
- head_tail_d_i, in, HtCapacity x head_tail_t, next head/tail table
- linked_data_d_i, in, MaxRdTxns x linked_data_t, next linked data
- match_in_id_i, in, id_t, AR ID to look up
- match_in_id_valid_i, in, 1, AR lookup valid
- rsp_id_i, in, id_t, R-channel ID to look up
- head_tail_q_o, out, HtCapacity x head_tail_t, registered table
- linked_data_q_o, out, MaxRdTxns x linked_data_t, registered array
- head_tail_free_idx_o, out, ht_idx_t, lowest free head/tail index
- linked_data_free_idx_o, out, ld_idx_t, lowest free linked-data index
- full_o, out, 1, no free entry in either structure
- no_in_id_match_o, out, 1, AR ID not present in table
- match_in_idx_o, out, ht_idx_t, lowest head/tail index with that ID
- id_exists_o, out, 1, R ID present in table
- rsp_idx_o, out, ht_idx_t, lowest head/tail index holding rsp_id_i
- accum_burst_length_o, out, accu_cnt_t, sum of (len+1) over non-free entries

## Operation
- State: head_tail_q, linked_data_q, prescaler counter presc_cnt (4 bits), tick flag.
- Each cycle: head_tail_q <= head_tail_d_i; linked_data_q <= linked_data_d_i, with aging applied.
- Aging on tick: for each entry i where linked_data_d_i[i].free == 0 and counter != 0, store counter-1. Counter saturates at 0 and never wraps. The entry i == linked_data_free_idx_o while enq_i is high is exempt, so a newly loaded budget is stored unmodified.
- Zero counters stay at 0. Timeout detection belongs to the manager.
- Free-index search: lowest index with free == 1. Index is 0 when none are free.
- full_o = (no free linked entry) OR (no free head/tail entry).
- AR match: among non-free head/tail entries with id == match_in_id_i, the lowest index drives match_in_idx_o. no_in_id_match_o = !found. When match_in_id_valid_i == 0, no_in_id_match_o = 1 and match_in_idx_o = 0.
- R match: same search on rsp_id_i, giving id_exists_o and rsp_idx_o. rsp_idx_o = 0 when not found.
- Accumulator: unsigned sum of len+1 over non-free linked entries, computed in a width with no overflow, then saturated to the accu_cnt_t maximum.

## Timing
- Reset (rst_i high, asynchronous): every entry has free = 1 and all other fields 0; presc_cnt = 0. Resulting outputs: free indices 0, full_o 0, no_in_id_match_o 1, id_exists_o 0, accum_burst_length_o 0, match/rsp indices 0.
- Reset asserted mid-operation discards all entries immediately. Aging resumes on the first edge after deassertion.
- Latency: manager write to visible q_o is one cycle. Lookup outputs are combinational from q, so they are valid in the same cycle as q.
- Simultaneous enqueue and dequeue of the same index: linked_data_d_i wins, and aging is skipped for that index when enq_i is high.

## Configuration
- RD_STORE_PRESCALER_EN defined:
  - presc_cnt counts down from presc_i to 0.
  - tick is asserted for one cycle when presc_cnt == 0, and presc_cnt reloads on that cycle.
  - presc_i == 0 gives a tick every cycle.
- RD_STORE_PRESCALER_EN undefined: tick = 1 every cycle, no presc_cnt register, and presc_i is ignored.

## Test plan
- Reset → all 8 linked and 8 head/tail entries free; full_o = 0; accum_burst_length_o = 0; linked_data_free_idx_o = 0.
- Enqueue ID 3, len 7, counter 20 at index 0 with prescaler off → the next cycle shows counter 20, then 19, 18… It holds at 0 after 20 more ticks and never wraps.
- Entries with len 3 and len 15 outstanding → accum_burst_length_o = 20. After the first is freed → 16.
- Fill all 8 linked entries → full_o = 1. Free entry 5 → linked_data_free_idx_o = 5 and full_o = 0.
- rsp_id_i = 3 with ID 3 at head/tail index 2 → id_exists_o = 1, rsp_idx_o = 2. rsp_id_i = 9 absent → id_exists_o = 0.
- With RD_STORE_PRESCALER_EN and presc_i = 3 → counter 10 decrements once every 4 cycles. Asserting rst_i mid-count frees everything within the same cycle.
